mem_io_ctrl: RTL and testbench

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

---
 rtl/mem_io_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_io_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - CPU memory/IO controller: RAM, LED register, switch port
//
// Purpose: decodes single CPU load/store transactions onto a synchronous RAM,
// a write-only LED register and a read-only synchronized switch port, and
// raises a sticky bus error on illegal or unmapped accesses.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_cmd, mem_addr     CPU command (00 none, 01 read, 10 write, 11 none), word address
//   write_data            CPU store data
//   read_data             registered load data
//   mem_rdy               transaction complete, held until mem_cmd returns to none
//   ram_addr, ram_din     RAM address / write data from the latched request
//   ram_we                RAM write enable, one cycle per RAM write
//   ram_dout              synchronous RAM read data
//   sw_in                 asynchronous slide switches
//   led_out               registered LED drive
//   bus_err               sticky error flag, cleared only by reset
module mem_io_ctrl #(
  parameter int         DATA_W   = 16,
  parameter int         RAM_AW   = 8,
  parameter logic [8:0] LED_ADDR = 9'h100,
  parameter logic [8:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [8:0]        mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_rdy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out,
  output logic              bus_err
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR, DONE} state_t;

  state_t state, state_n;

  logic [RAM_AW-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        sw_meta, sw_sync;

  logic is_rd, is_wr, is_ram, start;

  assign is_rd  = (mem_cmd == 2'b01);
  assign is_wr  = (mem_cmd == 2'b10);
  assign is_ram = ~mem_addr[8];
  // A request is only accepted from IDLE; everything after is driven from the latches.
  assign start  = (state == IDLE) && (is_rd || is_wr);

  assign ram_addr = addr_q;
  assign ram_din  = data_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (is_rd)      state_n = is_ram ? RD_WAIT : DONE;
        else if (is_wr) state_n = is_ram ? WR : DONE;
      end
      RD_WAIT: state_n = RD_CAP;   // RAM registers ram_addr on this edge
      RD_CAP:  state_n = DONE;     // ram_dout is valid here and gets captured
      WR:      state_n = DONE;
      DONE:    if (!(is_rd || is_wr)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_rdy = 1'b0;
    ram_we  = 1'b0;
    case (state)
      WR:      ram_we  = 1'b1;
      DONE:    mem_rdy = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request latches, switch synchronizer, IO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      read_data <= '0;
      led_out   <= '0;
      bus_err   <= 1'b0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;

      if (start) begin
        addr_q <= mem_addr[RAM_AW-1:0];
        data_q <= write_data;
        // IO and error accesses complete on the accepting edge.
        if (!is_ram) begin
          if (is_rd) begin
            if (mem_addr == SW_ADDR) begin
              read_data <= DATA_W'(sw_sync);
            end else begin
              read_data <= '0;
              bus_err   <= 1'b1;
            end
          end else begin
            if (mem_addr == LED_ADDR) led_out <= write_data[7:0];
            else                      bus_err <= 1'b1;
          end
        end
      end

      if (state == RD_CAP) read_data <= ram_dout;
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb/tb_mem_io_ctrl.sv - self-checking bench for mem_io_ctrl
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_rdy;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;
  logic        bus_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_io_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_rdy    (mem_rdy),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .sw_in      (sw_in),
    .led_out    (led_out),
    .bus_err    (bus_err)
  );

  // Synchronous RAM attached to the controller
  logic [15:0] ram [256] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic [7:0]  sw;
    int          lat;
    logic [15:0] rd;
    logic [7:0]  led;
    logic        err;
    int          we;
  } vec_t;

  vec_t tbl [12];

  // Transaction-level reference state
  logic [15:0] ref_mem [256];
  logic [15:0] ref_rd;
  logic [7:0]  ref_led;
  logic        ref_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_cmd = 2'b00; mem_addr = '0; write_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One complete transaction: present, wait for mem_rdy, hold, release.
  task automatic do_txn(input vec_t v, input string name);
    int lat = 0;
    int we_cnt = 0;
    @(negedge clk);
    sw_in = v.sw;
    repeat (2) @(negedge clk);
    mem_cmd = v.cmd; mem_addr = v.addr; write_data = v.wd;
    while (!mem_rdy && lat < 10) begin
      @(negedge clk);
      lat++;
      if (ram_we) begin
        we_cnt++;
        chk({name, ".ram_addr"}, 32'(ram_addr), 32'(v.addr[7:0]));
        chk({name, ".ram_din"}, 32'(ram_din), 32'(v.wd));
      end
      // The controller must ignore everything but NONE once a request is taken.
      mem_addr   = 9'($urandom);
      write_data = 16'($urandom);
      mem_cmd    = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    end
    chk({name, ".latency"}, 32'(lat), 32'(v.lat));
    chk({name, ".we_cycles"}, 32'(we_cnt), 32'(v.we));
    chk({name, ".read_data"}, 32'(read_data), 32'(v.rd));
    chk({name, ".led_out"}, 32'(led_out), 32'(v.led));
    chk({name, ".bus_err"}, 32'(bus_err), 32'(v.err));
    @(negedge clk);
    chk({name, ".rdy_hold"}, 32'(mem_rdy), 32'd1);
    chk({name, ".we_after"}, 32'(ram_we), 32'd0);
    mem_cmd = 2'b00;
    @(negedge clk);
    chk({name, ".rdy_drop"}, 32'(mem_rdy), 32'd0);
  endtask

  // Abstract model: outcome of a transaction from the address map rules.
  task automatic model(inout vec_t v);
    logic ram_sel;
    ram_sel = (v.addr < 9'h100);
    v.we  = 0;
    v.lat = 1;
    if (v.cmd == 2'b10) begin
      if (ram_sel) begin
        ref_mem[v.addr[7:0]] = v.wd;
        v.lat = 2;
        v.we  = 1;
      end else if (v.addr == 9'h100) begin
        ref_led = v.wd[7:0];
      end else begin
        ref_err = 1'b1;
      end
    end else begin
      if (ram_sel) begin
        ref_rd = ref_mem[v.addr[7:0]];
        v.lat  = 3;
      end else if (v.addr == 9'h140) begin
        ref_rd = {8'h00, v.sw};
      end else begin
        ref_rd  = 16'h0000;
        ref_err = 1'b1;
      end
    end
    v.rd  = ref_rd;
    v.led = ref_led;
    v.err = ref_err;
  endtask

  // Reset while the controller is in the middle of a RAM transaction.
  task automatic reset_mid(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                           input string name);
    @(negedge clk);
    mem_cmd = cmd; mem_addr = addr; write_data = wd;
    @(negedge clk);
    if (cmd == 2'b10) chk({name, ".we_before"}, 32'(ram_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_cmd = 2'b00;
    chk({name, ".rdy"}, 32'(mem_rdy), 32'd0);
    chk({name, ".we"}, 32'(ram_we), 32'd0);
    chk({name, ".led"}, 32'(led_out), 32'd0);
    chk({name, ".err"}, 32'(bus_err), 32'd0);
    chk({name, ".rd"}, 32'(read_data), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk({name, ".idle_rdy"}, 32'(mem_rdy), 32'd0);
      chk({name, ".idle_we"}, 32'(ram_we), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    //          cmd    addr     wd        sw     lat rd        led    err we
    tbl[0]  = '{2'b10, 9'h006, 16'hABCD, 8'h00, 2, 16'h0000, 8'h00, 1'b0, 1};
    tbl[1]  = '{2'b01, 9'h006, 16'h0000, 8'h00, 3, 16'hABCD, 8'h00, 1'b0, 0};
    tbl[2]  = '{2'b01, 9'h140, 16'h0000, 8'h5A, 1, 16'h005A, 8'h00, 1'b0, 0};
    tbl[3]  = '{2'b10, 9'h100, 16'h12C3, 8'h5A, 1, 16'h005A, 8'hC3, 1'b0, 0};
    tbl[4]  = '{2'b10, 9'h007, 16'h1111, 8'h5A, 2, 16'h005A, 8'hC3, 1'b0, 1};
    tbl[5]  = '{2'b01, 9'h1FF, 16'h0000, 8'h5A, 1, 16'h0000, 8'hC3, 1'b1, 0};
    tbl[6]  = '{2'b01, 9'h007, 16'h0000, 8'h5A, 3, 16'h1111, 8'hC3, 1'b1, 0};
    tbl[7]  = '{2'b10, 9'h140, 16'hFFFF, 8'h5A, 1, 16'h1111, 8'hC3, 1'b1, 0};
    tbl[8]  = '{2'b01, 9'h100, 16'h0000, 8'h5A, 1, 16'h0000, 8'hC3, 1'b1, 0};
    tbl[9]  = '{2'b10, 9'h1C0, 16'hBEEF, 8'h5A, 1, 16'h0000, 8'hC3, 1'b1, 0};
    tbl[10] = '{2'b10, 9'h0FF, 16'h8001, 8'h3C, 2, 16'h0000, 8'hC3, 1'b1, 1};
    tbl[11] = '{2'b01, 9'h0FF, 16'h0000, 8'h3C, 3, 16'h8001, 8'hC3, 1'b1, 0};

    reset = 1'b1; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; sw_in = 8'h00;
    do_reset();
    @(negedge clk);
    chk("reset.rdy", 32'(mem_rdy), 32'd0);
    chk("reset.we", 32'(ram_we), 32'd0);
    chk("reset.rd", 32'(read_data), 32'd0);
    chk("reset.led", 32'(led_out), 32'd0);
    chk("reset.err", 32'(bus_err), 32'd0);

    // Command 11 is treated as NONE
    mem_cmd = 2'b11; mem_addr = 9'h006; write_data = 16'h5555;
    repeat (3) begin
      @(negedge clk);
      chk("cmd11.rdy", 32'(mem_rdy), 32'd0);
      chk("cmd11.we", 32'(ram_we), 32'd0);
    end
    mem_cmd = 2'b00;

    for (int i = 0; i < 12; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

    reset_mid(2'b01, 9'h006, 16'h0000, "rst_rdwait");
    v = '{2'b10, 9'h100, 16'h0077, 8'h00, 1, 16'h0000, 8'h77, 1'b0, 0};
    do_txn(v, "pre_wr.led");
    v = '{2'b01, 9'h1FF, 16'h0000, 8'h00, 1, 16'h0000, 8'h77, 1'b1, 0};
    do_txn(v, "pre_wr.err");
    reset_mid(2'b10, 9'h010, 16'h5555, "rst_wr");

    // Randomized transactions against the reference model
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    ref_rd = 16'h0000; ref_led = 8'h00; ref_err = 1'b0;
    for (int i = 0; i < 60; i++) begin
      v.cmd = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      v.wd  = 16'($urandom);
      v.sw  = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 2: v.addr = 9'($urandom_range(9'h080, 9'h0FE));
        3:       v.addr = 9'h100;
        4:       v.addr = 9'h140;
        default: begin
          v.addr = 9'($urandom_range(9'h101, 9'h1FF));
          if (v.addr == 9'h140) v.addr = 9'h141;
        end
      endcase
      model(v);
      do_txn(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
